// File: rtl/morse_pkg.sv
// Shared types and helpers for the Morse trainer session controller.
package morse_pkg;

    localparam int NUM_LETTERS = 26;
    localparam int LETTER_W    = 5;
    localparam int SYM_W       = 2;
    localparam int NUM_SLOTS   = 5;
    localparam int PATTERN_W   = NUM_SLOTS * SYM_W;

    // Symbol codes as produced by button_to_morse.
    localparam logic [SYM_W-1:0] SYM_EMPTY   = 2'b00;
    localparam logic [SYM_W-1:0] SYM_DOT     = 2'b01;
    localparam logic [SYM_W-1:0] SYM_DASH    = 2'b10;
    localparam logic [SYM_W-1:0] SYM_INVALID = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CLEAR    = 3'd1,
        ST_WAIT     = 3'd2,
        ST_CHECK    = 3'd3,
        ST_FEEDBACK = 3'd4,
        ST_DONE     = 3'd5
    } state_e;

    // Fibonacci step: shift left, feedback from taps 7,5,4,3.
    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    // Map an LFSR value onto a letter index 0..25.
    function automatic logic [LETTER_W-1:0] lfsr_to_letter(input logic [7:0] l);
        return LETTER_W'(l % 8'd26);
    endfunction

endpackage

// File: rtl/morse_letter_rom.sv
// Reference Morse patterns for A-Z; slot one is in the top two bits.
module morse_letter_rom
    import morse_pkg::*;
(
    input  logic [LETTER_W-1:0]  letter_idx,
    output logic [PATTERN_W-1:0] pattern
);

    localparam logic [SYM_W-1:0] D = SYM_DOT;
    localparam logic [SYM_W-1:0] H = SYM_DASH;
    localparam logic [SYM_W-1:0] E = SYM_EMPTY;

    // Letter lookup; out-of-range indices return an all-invalid pattern that can never match.
    always_comb begin
        pattern = {NUM_SLOTS{SYM_INVALID}};
        case (letter_idx)
            5'd0:  pattern = {D, H, E, E, E};   // A
            5'd1:  pattern = {H, D, D, D, E};   // B
            5'd2:  pattern = {H, D, H, D, E};   // C
            5'd3:  pattern = {H, D, D, E, E};   // D
            5'd4:  pattern = {D, E, E, E, E};   // E
            5'd5:  pattern = {D, D, H, D, E};   // F
            5'd6:  pattern = {H, H, D, E, E};   // G
            5'd7:  pattern = {D, D, D, D, E};   // H
            5'd8:  pattern = {D, D, E, E, E};   // I
            5'd9:  pattern = {D, H, H, H, E};   // J
            5'd10: pattern = {H, D, H, E, E};   // K
            5'd11: pattern = {D, H, D, D, E};   // L
            5'd12: pattern = {H, H, E, E, E};   // M
            5'd13: pattern = {H, D, E, E, E};   // N
            5'd14: pattern = {H, H, H, E, E};   // O
            5'd15: pattern = {D, H, H, D, E};   // P
            5'd16: pattern = {H, H, D, H, E};   // Q
            5'd17: pattern = {D, H, D, E, E};   // R
            5'd18: pattern = {D, D, D, E, E};   // S
            5'd19: pattern = {H, E, E, E, E};   // T
            5'd20: pattern = {D, D, H, E, E};   // U
            5'd21: pattern = {D, D, D, H, E};   // V
            5'd22: pattern = {D, H, H, E, E};   // W
            5'd23: pattern = {H, D, D, H, E};   // X
            5'd24: pattern = {H, D, H, H, E};   // Y
            5'd25: pattern = {H, H, D, D, E};   // Z
            default: pattern = {NUM_SLOTS{SYM_INVALID}};
        endcase
    end

endmodule

// File: rtl/morse_trainer_sequencer.sv
// Session controller: picks a target letter, gates the keying datapath,
// grades each decoded letter or an idle timeout, and counts rounds and score.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  IDLE     | no session; datapath held clear; waits for start
//  CLEAR    | one cycle; datapath cleared; target latched, LFSR advanced
//  WAIT     | target shown; user keys; timeout timer running
//  CHECK    | one cycle; decoded symbols compared with the reference
//  FEEDBACK | verdict held for FEEDBACK_TICKS cycles; then next round
//  DONE     | session complete; counts held until start
module morse_trainer_sequencer
    import morse_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS     = 10,
    parameter int unsigned TIMEOUT_TICKS  = 100,
    parameter int unsigned FEEDBACK_TICKS = 20,
    parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [SYM_W-1:0]    morse_one,
    input  logic [SYM_W-1:0]    morse_two,
    input  logic [SYM_W-1:0]    morse_three,
    input  logic [SYM_W-1:0]    morse_four,
    input  logic [SYM_W-1:0]    morse_five,
    input  logic                letter_done,
    output logic                morse_clear,
    output logic [LETTER_W-1:0] target_letter,
    output logic                target_valid,
    output logic                result_correct,
    output logic                result_wrong,
    output logic                timed_out,
    output logic [7:0]          round_num,
    output logic [7:0]          score,
    output logic                session_done
);

    localparam int TIMER_W = 16;
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST  = TIMER_W'(TIMEOUT_TICKS - 1);
    localparam logic [TIMER_W-1:0] FEEDBACK_LAST = TIMER_W'(FEEDBACK_TICKS - 1);
    localparam logic [7:0]         ROUNDS_END    = 8'(NUM_ROUNDS);

    state_e                state_q, state_d;
    logic [TIMER_W-1:0]    timer_q, timer_d;
    logic [7:0]            lfsr_q, lfsr_d;
    logic [LETTER_W-1:0]   target_q, target_d;
    logic [7:0]            round_q, round_d;
    logic [7:0]            score_q, score_d;
    logic                  correct_q, correct_d;
    logic                  wrong_q, wrong_d;
    logic                  timeout_q, timeout_d;
    logic                  clear_q, clear_d;
    logic                  valid_q, valid_d;
    logic                  done_q, done_d;

    logic [PATTERN_W-1:0]  ref_pattern;
    logic [PATTERN_W-1:0]  keyed_pattern;
    logic [7:0]            round_inc;

    morse_letter_rom u_rom (
        .letter_idx (target_q),
        .pattern    (ref_pattern)
    );

    // Symbols are compared live in CHECK; the datapath holds them because morse_clear stays low.
    assign keyed_pattern = {morse_one, morse_two, morse_three, morse_four, morse_five};
    assign round_inc     = (round_q == 8'hFF) ? round_q : round_q + 8'd1;

    // Next-state, counters and registered-output values.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        lfsr_d    = lfsr_q;
        target_d  = target_q;
        round_d   = round_q;
        score_d   = score_q;
        correct_d = correct_q;
        wrong_d   = wrong_q;
        timeout_d = timeout_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_CLEAR;
                    round_d = 8'd0;
                    score_d = 8'd0;
                end
            end
            ST_CLEAR: begin
                target_d = lfsr_to_letter(lfsr_q);
                lfsr_d   = lfsr_step(lfsr_q);
                timer_d  = '0;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (letter_done) begin
                    state_d = ST_CHECK;
                end else if (timer_q == TIMEOUT_LAST) begin
                    state_d   = ST_FEEDBACK;
                    wrong_d   = 1'b1;
                    timeout_d = 1'b1;
                    timer_d   = '0;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            ST_CHECK: begin
                state_d   = ST_FEEDBACK;
                timer_d   = '0;
                timeout_d = 1'b0;
                if (keyed_pattern == ref_pattern) begin
                    correct_d = 1'b1;
                    if (score_q != 8'hFF) begin
                        score_d = score_q + 8'd1;
                    end
                end else begin
                    wrong_d = 1'b1;
                end
            end
            ST_FEEDBACK: begin
                if (timer_q == FEEDBACK_LAST) begin
                    correct_d = 1'b0;
                    wrong_d   = 1'b0;
                    timeout_d = 1'b0;
                    timer_d   = '0;
                    round_d   = round_inc;
                    state_d   = (round_inc == ROUNDS_END) ? ST_DONE : ST_CLEAR;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides everything except reset; counters and target keep their values.
        if (abort) begin
            state_d   = ST_IDLE;
            timer_d   = '0;
            lfsr_d    = lfsr_q;
            target_d  = target_q;
            round_d   = round_q;
            score_d   = score_q;
            correct_d = 1'b0;
            wrong_d   = 1'b0;
            timeout_d = 1'b0;
        end

        clear_d = (state_d == ST_IDLE) || (state_d == ST_CLEAR) ||
                  (state_d == ST_FEEDBACK) || (state_d == ST_DONE);
        valid_d = (state_d == ST_WAIT);
        done_d  = (state_d == ST_DONE);
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            lfsr_q    <= LFSR_SEED;
            target_q  <= '0;
            round_q   <= 8'd0;
            score_q   <= 8'd0;
            correct_q <= 1'b0;
            wrong_q   <= 1'b0;
            timeout_q <= 1'b0;
            clear_q   <= 1'b1;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            lfsr_q    <= lfsr_d;
            target_q  <= target_d;
            round_q   <= round_d;
            score_q   <= score_d;
            correct_q <= correct_d;
            wrong_q   <= wrong_d;
            timeout_q <= timeout_d;
            clear_q   <= clear_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
        end
    end

    assign morse_clear    = clear_q;
    assign target_letter  = target_q;
    assign target_valid   = valid_q;
    assign result_correct = correct_q;
    assign result_wrong   = wrong_q;
    assign timed_out      = timeout_q;
    assign round_num      = round_q;
    assign score          = score_q;
    assign session_done   = done_q;

endmodule

// File: tb/tb_morse_trainer_sequencer.sv
// Self-checking bench for morse_trainer_sequencer: a table of hand-chosen rounds,
// randomized rounds graded by a string-based Morse model, plus abort and reset sequences.
module tb_morse_trainer_sequencer;

    localparam int NR   = 3;
    localparam int TO   = 8;
    localparam int FB   = 4;
    localparam int SEED = 8'hA5;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [1:0] morse_one = 2'b00, morse_two = 2'b00, morse_three = 2'b00;
    logic [1:0] morse_four = 2'b00, morse_five = 2'b00;
    logic       letter_done = 1'b0;
    logic       morse_clear;
    logic [4:0] target_letter;
    logic       target_valid, result_correct, result_wrong, timed_out, session_done;
    logic [7:0] round_num, score;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    int m_lfsr  = SEED;
    int m_round = 0;
    int m_score = 0;

    string morse_str [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                              ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                              "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};

    typedef struct {
        bit         start_before;
        int         delay;
        logic [9:0] syms;
        int         exp_target;
        bit         exp_correct;
        bit         exp_timeout;
    } vec_t;

    vec_t vecs [6];

    morse_trainer_sequencer #(
        .NUM_ROUNDS     (NR),
        .TIMEOUT_TICKS  (TO),
        .FEEDBACK_TICKS (FB),
        .LFSR_SEED      (8'(SEED))
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .abort          (abort),
        .morse_one      (morse_one),
        .morse_two      (morse_two),
        .morse_three    (morse_three),
        .morse_four     (morse_four),
        .morse_five     (morse_five),
        .letter_done    (letter_done),
        .morse_clear    (morse_clear),
        .target_letter  (target_letter),
        .target_valid   (target_valid),
        .result_correct (result_correct),
        .result_wrong   (result_wrong),
        .timed_out      (timed_out),
        .round_num      (round_num),
        .score          (score),
        .session_done   (session_done)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic int lfsr_next(input int l);
        int nb;
        nb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
        return ((l << 1) | nb) & 255;
    endfunction

    function automatic logic [9:0] ref_code(input int idx);
        string      s;
        logic [9:0] c;
        s = morse_str[idx];
        c = '0;
        for (int i = 0; i < 5; i++) begin
            if (i < s.len()) c[9-2*i -: 2] = (s.getc(i) == 8'h2E) ? 2'b01 : 2'b10;
        end
        return c;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_syms(input logic [9:0] s);
        {morse_one, morse_two, morse_three, morse_four, morse_five} = s;
    endtask

    // Start a session from IDLE or DONE; DUT is left in CLEAR.
    task automatic do_start();
        if (m_round == NR) begin
            letter_done = 1'b1;
            step();
            letter_done = 1'b0;
            step();
            chk("done_hold_flag", session_done, 1);
            chk("done_hold_score", score, m_score);
            chk("done_hold_round", round_num, NR);
            chk("done_hold_mc", morse_clear, 1);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        m_round = 0;
        m_score = 0;
        chk("start_round", round_num, 0);
        chk("start_score", score, 0);
        chk("start_done", session_done, 0);
        chk("clear_mc", morse_clear, 1);
        chk("clear_tv", target_valid, 0);
    endtask

    // One round starting in CLEAR; ends in the state after FEEDBACK.
    task automatic run_round(input int delay, input logic [9:0] syms, input int exp_t,
                             input bit exp_c, input bit exp_to);
        set_syms(syms);
        step();
        chk("wait_tv", target_valid, 1);
        chk("wait_mc", morse_clear, 0);
        chk("target", target_letter, exp_t);
        if (delay < TO) begin
            repeat (delay) begin
                step();
                chk("wait_hold_tv", target_valid, 1);
            end
            letter_done = 1'b1;
            step();
            letter_done = 1'b0;
            chk("check_mc", morse_clear, 0);
            chk("check_no_verdict", result_correct | result_wrong, 0);
            step();
        end else begin
            repeat (TO - 1) begin
                step();
                chk("wait_hold_tv", target_valid, 1);
                chk("early_verdict", result_wrong | timed_out, 0);
            end
            step();
        end
        if (exp_c && m_score < 255) m_score++;
        chk("fb_correct", result_correct, exp_c);
        chk("fb_wrong", result_wrong, !exp_c);
        chk("fb_timeout", timed_out, exp_to);
        chk("fb_mc", morse_clear, 1);
        chk("fb_tv", target_valid, 0);
        chk("fb_score", score, m_score);
        chk("fb_round", round_num, m_round);
        repeat (FB - 1) begin
            step();
            chk("fb_hold", {result_correct, result_wrong}, exp_c ? 2 : 1);
        end
        step();
        m_round++;
        chk("post_round", round_num, m_round);
        chk("post_verdict", {result_correct, result_wrong, timed_out}, 0);
        chk("post_done", session_done, (m_round == NR) ? 1 : 0);
        chk("post_mc", morse_clear, 1);
    endtask

    task automatic random_round();
        int t, d, ch, k;
        logic [9:0] s, rc;
        t = m_lfsr % 26;
        m_lfsr = lfsr_next(m_lfsr);
        rc = ref_code(t);
        d  = $urandom_range(0, TO + 1);
        ch = $urandom_range(0, 3);
        s  = rc;
        if (ch == 2) begin
            k = $urandom_range(0, 4);
            s[9-2*k -: 2] = 2'($urandom_range(0, 3));
        end else if (ch == 3) begin
            s = 10'($urandom);
        end
        run_round(d, s, t, (d < TO) && (s == rc), d >= TO);
    endtask

    initial begin
        int t;
        vecs[0] = '{1'b1, 2, 10'b01_10_10_10_00, 9,  1'b1, 1'b0};
        vecs[1] = '{1'b0, 7, 10'b01_10_10_00_00, 22, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 0, 10'b10_00_00_00_00, 19, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 3, 10'b01_10_10_00_00, 16, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 8, 10'b10_10_01_00_00, 6,  1'b0, 1'b1};
        vecs[5] = '{1'b0, 5, 10'b10_01_00_00_11, 13, 1'b0, 1'b0};

        // Reset values
        step();
        step();
        reset = 1'b0;
        step();
        chk("rst_mc", morse_clear, 1);
        chk("rst_target", target_letter, 0);
        chk("rst_tv", target_valid, 0);
        chk("rst_verdict", {result_correct, result_wrong, timed_out}, 0);
        chk("rst_round", round_num, 0);
        chk("rst_score", score, 0);
        chk("rst_done", session_done, 0);

        // letter_done in IDLE is ignored
        letter_done = 1'b1;
        step();
        letter_done = 1'b0;
        step();
        chk("idle_ld_mc", morse_clear, 1);
        chk("idle_ld_tv", target_valid, 0);
        chk("idle_ld_verdict", {result_correct, result_wrong}, 0);

        // Table-driven rounds: two sessions with known LFSR targets
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].start_before) do_start();
            m_lfsr = lfsr_next(m_lfsr);
            run_round(vecs[i].delay, vecs[i].syms, vecs[i].exp_target,
                      vecs[i].exp_correct, vecs[i].exp_timeout);
        end

        // Randomized sessions against the model
        repeat (8) begin
            do_start();
            for (int r = 0; r < NR; r++) random_round();
        end

        // Abort in WAIT of the second round
        do_start();
        random_round();
        t = m_lfsr % 26;
        m_lfsr = lfsr_next(m_lfsr);
        step();
        chk("abort_pre_target", target_letter, t);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_mc", morse_clear, 1);
        chk("abort_tv", target_valid, 0);
        chk("abort_round", round_num, 1);
        chk("abort_score", score, m_score);
        chk("abort_verdict", {result_correct, result_wrong, timed_out}, 0);
        set_syms(ref_code(t));
        letter_done = 1'b1;
        step();
        letter_done = 1'b0;
        step();
        chk("abort_idle_mc", morse_clear, 1);
        chk("abort_idle_tv", target_valid, 0);
        chk("abort_idle_round", round_num, 1);
        chk("abort_idle_correct", result_correct, 0);

        // Reset during FEEDBACK
        do_start();
        t = m_lfsr % 26;
        m_lfsr = lfsr_next(m_lfsr);
        set_syms(ref_code(t));
        step();
        letter_done = 1'b1;
        step();
        letter_done = 1'b0;
        step();
        chk("pre_rst_correct", result_correct, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("fbrst_mc", morse_clear, 1);
        chk("fbrst_correct", result_correct, 0);
        chk("fbrst_score", score, 0);
        chk("fbrst_round", round_num, 0);
        chk("fbrst_target", target_letter, 0);
        chk("fbrst_tv", target_valid, 0);
        m_lfsr = SEED;
        m_round = 0;
        m_score = 0;
        do_start();
        step();
        chk("reseed_target", target_letter, 9);
        chk("reseed_tv", target_valid, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
